// File: rtl/nterm_sm_pkg.sv
// nterm_sm_pkg
// Shared definitions for the N-terminal configurable switch matrix:
//   - mode_t      : per-class turn-back mode (reverse, straight, zero, one)
//   - CLS_*       : class index, selects cfg_active[2k+1:2k]
//   - CFG_BITS    : width of the serial configuration word (2 bits x 5 classes)
//   - cfg_state_t : serial configuration loader states
package nterm_sm_pkg;

    typedef enum logic [1:0] {
        MODE_REV  = 2'b00,
        MODE_STR  = 2'b01,
        MODE_ZERO = 2'b10,
        MODE_ONE  = 2'b11
    } mode_t;

    localparam int CLS_S1  = 0;
    localparam int CLS_S2  = 1;
    localparam int CLS_S2B = 2;
    localparam int CLS_S4  = 3;
    localparam int CLS_SS4 = 4;

    localparam int CFG_BITS = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/nterm_lane_map.sv
// nterm_lane_map
// Maps one north-terminating wire class onto its south-going begins.
// Ports:
//   lane_in  [W-1:0] : north ends of the class
//   mode     [1:0]   : turn-back mode for this class
//   lane_out [W-1:0] : south begins of the class
module nterm_lane_map
    import nterm_sm_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] lane_in,
    input  mode_t        mode,
    output logic [W-1:0] lane_out
);

    // Reverse is the legacy fixed-matrix wiring; the rest are run-time options.
    always_comb begin
        lane_out = '0;
        unique case (mode)
            MODE_REV: begin
                for (int i = 0; i < W; i++) begin
                    lane_out[i] = lane_in[W-1-i];
                end
            end
            MODE_STR:  lane_out = lane_in;
            MODE_ZERO: lane_out = '0;
            MODE_ONE:  lane_out = '1;
        endcase
    end

endmodule

// File: rtl/n_term_cfg_switch_matrix.sv
// n_term_cfg_switch_matrix
// Top-row N-terminal switch matrix: turns the north-flowing wire classes back
// south, each class in a run-time mode taken from a serially loaded config
// word that is committed atomically.
// Ports:
//   CLK, resetn           : fabric clock, asynchronous active-low reset
//   n1end/n2mid/n2end/
//   n4end/nn4end          : north wire ends (W1, W2, W2, W4, WNN4 lanes)
//   s1beg/s2beg/s2begb/
//   s4beg/ss4beg          : south wire begins
//   cfg_valid, cfg_data   : serial config bit, LSB first
//   cfg_ready             : a config bit is accepted this cycle
//   cfg_done              : one-cycle pulse in the commit cycle
//   cfg_active            : readback of the active config word
// Build option:
//   NTERM_SM_REG_OUT_EN   : register all five output buses (1 cycle latency,
//                           reset to zero); otherwise outputs are combinational.
module n_term_cfg_switch_matrix
    import nterm_sm_pkg::*;
#(
    parameter int W1   = 4,
    parameter int W2   = 8,
    parameter int W4   = 16,
    parameter int WNN4 = 16
) (
    input  logic                CLK,
    input  logic                resetn,
    input  logic [W1-1:0]       n1end,
    input  logic [W2-1:0]       n2mid,
    input  logic [W2-1:0]       n2end,
    input  logic [W4-1:0]       n4end,
    input  logic [WNN4-1:0]     nn4end,
    output logic [W1-1:0]       s1beg,
    output logic [W2-1:0]       s2beg,
    output logic [W2-1:0]       s2begb,
    output logic [W4-1:0]       s4beg,
    output logic [WNN4-1:0]     ss4beg,
    input  logic                cfg_valid,
    input  logic                cfg_data,
    output logic                cfg_ready,
    output logic                cfg_done,
    output logic [CFG_BITS-1:0] cfg_active
);

    localparam int CNT_W = $clog2(CFG_BITS + 1);

    cfg_state_t          state_q,  state_d;
    logic [CNT_W-1:0]    count_q,  count_d;
    logic [CFG_BITS-1:0] shadow_q, shadow_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic                done_q,   done_d;
    logic                ready_q,  ready_d;
    logic                handshake;

    assign handshake = cfg_valid & ready_q;

    // Loader next-state. Bits shift in from the top so that after CFG_BITS
    // handshakes the first bit sent sits in bit 0. ready and done are
    // registered, so they are computed for the state being entered.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shadow_d = shadow_q;
        active_d = active_q;
        done_d   = 1'b0;
        ready_d  = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    shadow_d = {cfg_data, shadow_q[CFG_BITS-1:1]};
                    count_d  = CNT_W'(1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (handshake) begin
                    shadow_d = {cfg_data, shadow_q[CFG_BITS-1:1]};
                    count_d  = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(CFG_BITS - 1)) begin
                        state_d = COMMIT;
                        done_d  = 1'b1;
                        ready_d = 1'b0;
                    end
                end
            end
            COMMIT: begin
                active_d = shadow_q;
                count_d  = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Loader state and registered handshake outputs; reset drops any partial load.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            count_q  <= '0;
            shadow_q <= '0;
            active_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign cfg_ready  = ready_q;
    assign cfg_done   = done_q;
    assign cfg_active = active_q;

    logic [W1-1:0]   s1_map;
    logic [W2-1:0]   s2_map;
    logic [W2-1:0]   s2b_map;
    logic [W4-1:0]   s4_map;
    logic [WNN4-1:0] ss4_map;

    nterm_lane_map #(.W(W1)) u_map_s1 (
        .lane_in  (n1end),
        .mode     (mode_t'(active_q[2*CLS_S1 +: 2])),
        .lane_out (s1_map)
    );

    nterm_lane_map #(.W(W2)) u_map_s2 (
        .lane_in  (n2mid),
        .mode     (mode_t'(active_q[2*CLS_S2 +: 2])),
        .lane_out (s2_map)
    );

    nterm_lane_map #(.W(W2)) u_map_s2b (
        .lane_in  (n2end),
        .mode     (mode_t'(active_q[2*CLS_S2B +: 2])),
        .lane_out (s2b_map)
    );

    nterm_lane_map #(.W(W4)) u_map_s4 (
        .lane_in  (n4end),
        .mode     (mode_t'(active_q[2*CLS_S4 +: 2])),
        .lane_out (s4_map)
    );

    nterm_lane_map #(.W(WNN4)) u_map_ss4 (
        .lane_in  (nn4end),
        .mode     (mode_t'(active_q[2*CLS_SS4 +: 2])),
        .lane_out (ss4_map)
    );

`ifdef NTERM_SM_REG_OUT_EN
    logic [W1-1:0]   s1_q;
    logic [W2-1:0]   s2_q;
    logic [W2-1:0]   s2b_q;
    logic [W4-1:0]   s4_q;
    logic [WNN4-1:0] ss4_q;

    // Output pipeline stage; all buses read zero while in reset.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s2b_q <= '0;
            s4_q  <= '0;
            ss4_q <= '0;
        end else begin
            s1_q  <= s1_map;
            s2_q  <= s2_map;
            s2b_q <= s2b_map;
            s4_q  <= s4_map;
            ss4_q <= ss4_map;
        end
    end

    assign s1beg  = s1_q;
    assign s2beg  = s2_q;
    assign s2begb = s2b_q;
    assign s4beg  = s4_q;
    assign ss4beg = ss4_q;
`else
    assign s1beg  = s1_map;
    assign s2beg  = s2_map;
    assign s2begb = s2b_map;
    assign s4beg  = s4_map;
    assign ss4beg = ss4_map;
`endif

endmodule

// File: tb/tb_n_term_cfg_switch_matrix.sv
// tb_n_term_cfg_switch_matrix
// Directed bench for n_term_cfg_switch_matrix: reset defaults, serial config
// loading with commit timing, per-class modes, reset during a partial load and
// gapped loading with a bit offered during the commit cycle.
module tb_n_term_cfg_switch_matrix;

    logic        CLK = 1'b0;
    logic        resetn;
    logic [3:0]  n1end;
    logic [7:0]  n2mid;
    logic [7:0]  n2end;
    logic [15:0] n4end;
    logic [15:0] nn4end;
    logic [3:0]  s1beg;
    logic [7:0]  s2beg;
    logic [7:0]  s2begb;
    logic [15:0] s4beg;
    logic [15:0] ss4beg;
    logic        cfg_valid;
    logic        cfg_data;
    logic        cfg_ready;
    logic        cfg_done;
    logic [9:0]  cfg_active;

    int compare_count  = 0;
    int mismatch_count = 0;

`ifdef NTERM_SM_REG_OUT_EN
    localparam logic [15:0] RST_S1 = 16'h0000;
    localparam logic [15:0] RST_S4 = 16'h0000;
`else
    localparam logic [15:0] RST_S1 = 16'h000C;
    localparam logic [15:0] RST_S4 = 16'h8000;
`endif

    n_term_cfg_switch_matrix #(
        .W1   (4),
        .W2   (8),
        .W4   (16),
        .WNN4 (16)
    ) dut (
        .CLK        (CLK),
        .resetn     (resetn),
        .n1end      (n1end),
        .n2mid      (n2mid),
        .n2end      (n2end),
        .n4end      (n4end),
        .nn4end     (nn4end),
        .s1beg      (s1beg),
        .s2beg      (s2beg),
        .s2begb     (s2begb),
        .s4beg      (s4beg),
        .ss4beg     (ss4beg),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .cfg_done   (cfg_done),
        .cfg_active (cfg_active)
    );

    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Let the data path reflect new inputs / config.
    task automatic settle();
`ifdef NTERM_SM_REG_OUT_EN
        step();
`else
        #1;
`endif
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compare_count++;
        assert (observed === expected) else begin
            mismatch_count++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Send n bits LSB first, with gap idle cycles between consecutive bits.
    task automatic applyStimulus(input logic [9:0] bits, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                cfg_valid = 1'b0;
                repeat (gap) step();
            end
            cfg_valid = 1'b1;
            cfg_data  = bits[i];
            step();
        end
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
        n1end     = 4'b0011;
        n2mid     = 8'h01;
        n2end     = 8'h03;
        n4end     = 16'h0001;
        nn4end    = 16'h0003;
        #2;
        $display("[TB] reset phase");
        checkOutput("rst_during_s1beg", 16'(s1beg), RST_S1);
        checkOutput("rst_during_s4beg", s4beg, RST_S4);

        n1end = 4'b0001;
        @(negedge CLK);
        resetn = 1'b1;
        step();
        settle();
        checkOutput("rst_s1beg", 16'(s1beg), 16'h0008);
        checkOutput("rst_s4beg", s4beg, 16'h8000);
        checkOutput("rst_s2beg", 16'(s2beg), 16'h0080);
        checkOutput("rst_s2begb", 16'(s2begb), 16'h00C0);
        checkOutput("rst_ss4beg", ss4beg, 16'hC000);
        checkOutput("rst_active", 16'(cfg_active), 16'h0000);
        checkOutput("rst_ready", 16'(cfg_ready), 16'h0001);
        checkOutput("rst_done", 16'(cfg_done), 16'h0000);

        $display("[TB] load single straight");
        applyStimulus(10'h001, 10, 0);
        checkOutput("l1_done_pulse", 16'(cfg_done), 16'h0001);
        checkOutput("l1_ready_low", 16'(cfg_ready), 16'h0000);
        checkOutput("l1_active_held", 16'(cfg_active), 16'h0000);
        step();
        checkOutput("l1_done_end", 16'(cfg_done), 16'h0000);
        checkOutput("l1_ready_back", 16'(cfg_ready), 16'h0001);
        checkOutput("l1_active", 16'(cfg_active), 16'h0001);
        n1end = 4'b0011;
        settle();
        checkOutput("l1_s1beg", 16'(s1beg), 16'h0003);
        checkOutput("l1_s4beg", s4beg, 16'h8000);
        checkOutput("l1_s2beg", 16'(s2beg), 16'h0080);

        $display("[TB] load mixed modes");
        n2end = 8'hA5;
        n2mid = 8'h0F;
        applyStimulus(10'h390, 10, 0);
        step();
        checkOutput("l2_active", 16'(cfg_active), 16'h0390);
        settle();
        checkOutput("l2_ss4beg", ss4beg, 16'hFFFF);
        checkOutput("l2_s4beg", s4beg, 16'h0000);
        checkOutput("l2_s2begb", 16'(s2begb), 16'h00A5);
        checkOutput("l2_s2beg", 16'(s2beg), 16'h00F0);
        checkOutput("l2_s1beg", 16'(s1beg), 16'h000C);

`ifdef NTERM_SM_REG_OUT_EN
        n2mid = 8'h03;
        #1;
        checkOutput("reg_s2beg_old", 16'(s2beg), 16'h00F0);
        step();
        checkOutput("reg_s2beg_new", 16'(s2beg), 16'h00C0);
        n2mid = 8'h0F;
        step();
`endif

        $display("[TB] reset during partial load");
        applyStimulus(10'h3FF, 5, 0);
        checkOutput("p_active_stable", 16'(cfg_active), 16'h0390);
        checkOutput("p_ss4beg_stable", ss4beg, 16'hFFFF);
        #3;
        resetn = 1'b0;
        #1;
        checkOutput("p_rst_active", 16'(cfg_active), 16'h0000);
        checkOutput("p_rst_ready", 16'(cfg_ready), 16'h0001);
        checkOutput("p_rst_s4beg", s4beg, RST_S4);
        checkOutput("p_rst_s1beg", 16'(s1beg), RST_S1);
        @(negedge CLK);
        resetn = 1'b1;
        step();
        applyStimulus(10'h3FF, 10, 0);
        checkOutput("p_done_pulse", 16'(cfg_done), 16'h0001);
        step();
        checkOutput("p_active", 16'(cfg_active), 16'h03FF);
        settle();
        checkOutput("p_s1beg", 16'(s1beg), 16'h000F);
        checkOutput("p_s4beg", s4beg, 16'hFFFF);

        $display("[TB] gapped load with bit during commit");
        applyStimulus(10'h2B5, 10, 2);
        checkOutput("g_done_pulse", 16'(cfg_done), 16'h0001);
        cfg_valid = 1'b1;
        cfg_data  = 1'b1;
        step();
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
        checkOutput("g_done_end", 16'(cfg_done), 16'h0000);
        checkOutput("g_active", 16'(cfg_active), 16'h02B5);
        settle();
        checkOutput("g_s1beg", 16'(s1beg), 16'h0003);
        checkOutput("g_s2beg", 16'(s2beg), 16'h000F);
        checkOutput("g_s2begb", 16'(s2begb), 16'h00FF);
        checkOutput("g_ss4beg", ss4beg, 16'h0000);

        n2end = 8'h01;
        applyStimulus(10'h0CA, 10, 1);
        checkOutput("g2_done_pulse", 16'(cfg_done), 16'h0001);
        step();
        checkOutput("g2_active", 16'(cfg_active), 16'h00CA);
        settle();
        checkOutput("g2_s1beg", 16'(s1beg), 16'h0000);
        checkOutput("g2_s2beg", 16'(s2beg), 16'h0000);
        checkOutput("g2_s4beg", s4beg, 16'hFFFF);
        checkOutput("g2_s2begb", 16'(s2begb), 16'h0080);
        checkOutput("g2_ss4beg", ss4beg, 16'hC000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
